// File: rtl/csa_pipe_adder_pkg.sv
// Shared defaults and mode constants for the pipelined carry-select adder.
// Imported by the adder RTL and by its testbench.
package csa_pipe_adder_pkg;

    localparam int unsigned WIDTH_DEF      = 32;
    localparam int unsigned BLOCK_DEF      = 8;
    localparam int unsigned STAGE_BLKS_DEF = 2;
    localparam int unsigned NUM_BLK_DEF    = WIDTH_DEF / BLOCK_DEF;
    localparam int unsigned LAT_DEF        = NUM_BLK_DEF / STAGE_BLKS_DEF;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/csa_segment.sv
// One carry-select segment: sums for carry-in 0 and 1 are formed in parallel,
// and the real carry-in only drives the final select.
module csa_segment #(
    parameter int unsigned BLOCK = 8
) (
    input  logic [BLOCK-1:0] x,
    input  logic [BLOCK-1:0] y,
    input  logic             ci,
    output logic [BLOCK-1:0] s,
    output logic             co
);

    logic [BLOCK:0] r0;
    logic [BLOCK:0] r1;

    always_comb begin
        r0      = {1'b0, x} + {1'b0, y};
        r1      = {1'b0, x} + {1'b0, y} + {{BLOCK{1'b0}}, 1'b1};
        {co, s} = ci ? r1 : r0;
    end

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor with a valid/ready stream interface.
// Each stage resolves STAGE_BLKS segments; one global enable stalls the whole pipe.
module csa_pipe_adder
    import csa_pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned BLOCK      = BLOCK_DEF,
    parameter int unsigned STAGE_BLKS = STAGE_BLKS_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NUM_BLK = WIDTH / BLOCK;
    localparam int unsigned LAT     = NUM_BLK / STAGE_BLKS;
    localparam int unsigned SW      = STAGE_BLKS * BLOCK;
    localparam int unsigned MSB     = WIDTH - 1;

    if (WIDTH % BLOCK != 0) begin : g_bad_width
        $error("csa_pipe_adder: WIDTH must be a multiple of BLOCK");
    end
    if (NUM_BLK % STAGE_BLKS != 0) begin : g_bad_stage
        $error("csa_pipe_adder: WIDTH/BLOCK must be a multiple of STAGE_BLKS");
    end

    logic             adv;
    logic [LAT-1:0]   vld_q, vld_d;
    logic [LAT-1:0]   c_q, c_d;
    logic [WIDTH-1:0] a_q  [LAT];
    logic [WIDTH-1:0] a_d  [LAT];
    logic [WIDTH-1:0] bx_q [LAT];
    logic [WIDTH-1:0] bx_d [LAT];
    logic [WIDTH-1:0] s_q  [LAT];
    logic [WIDTH-1:0] s_d  [LAT];
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] st_a  [LAT];
    logic [WIDTH-1:0] st_bx [LAT];
    logic [WIDTH-1:0] st_s  [LAT];
    logic [LAT-1:0]   st_c;

    logic [WIDTH-1:0]   seg_s;
    logic [NUM_BLK-1:0] seg_ci;
    logic [NUM_BLK-1:0] seg_co;
    logic               unused_bits;

    assign adv       = !vld_q[LAT-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[LAT-1];
    assign sum       = s_q[LAT-1];
    assign cout      = c_q[LAT-1];
    assign ovf       = ovf_q;

    // Stage 0 sees the raw operands; later stages see the previous stage registers.
    always_comb begin
        st_a[0]  = a;
        st_bx[0] = sub ? ~b : b;
        st_s[0]  = '0;
        st_c     = '0;
        st_c[0]  = cin;
        for (int unsigned k = 1; k < LAT; k++) begin
            st_a[k]  = a_q[k-1];
            st_bx[k] = bx_q[k-1];
            st_s[k]  = s_q[k-1];
            st_c[k]  = c_q[k-1];
        end
    end

    for (genvar g = 0; g < NUM_BLK; g++) begin : g_seg
        if (g % STAGE_BLKS == 0) begin : g_first
            assign seg_ci[g] = st_c[g / STAGE_BLKS];
        end else begin : g_chain
            assign seg_ci[g] = seg_co[g-1];
        end
        csa_segment #(.BLOCK(BLOCK)) u_seg (
            .x  (st_a[g / STAGE_BLKS][g*BLOCK +: BLOCK]),
            .y  (st_bx[g / STAGE_BLKS][g*BLOCK +: BLOCK]),
            .ci (seg_ci[g]),
            .s  (seg_s[g*BLOCK +: BLOCK]),
            .co (seg_co[g])
        );
    end

    always_comb begin
        vld_d    = '0;
        vld_d[0] = in_valid;
        for (int unsigned k = 1; k < LAT; k++) begin
            vld_d[k] = vld_q[k-1];
        end
        c_d = '0;
        for (int unsigned k = 0; k < LAT; k++) begin
            a_d[k]             = st_a[k];
            bx_d[k]            = st_bx[k];
            s_d[k]             = st_s[k];
            s_d[k][k*SW +: SW] = seg_s[k*SW +: SW];
            c_d[k]             = seg_co[k*STAGE_BLKS + STAGE_BLKS - 1];
        end
        ovf_d = (st_a[LAT-1][MSB] == st_bx[LAT-1][MSB]) &&
                (s_d[LAT-1][MSB] != st_a[LAT-1][MSB]);
    end

    // Operand bits already consumed by earlier stages are carried but never read.
    always_comb begin
        unused_bits = 1'b0;
        for (int unsigned k = 0; k < LAT; k++) begin
            unused_bits = unused_bits ^ (^a_q[k]) ^ (^bx_q[k]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int unsigned k = 0; k < LAT; k++) begin
                a_q[k]  <= '0;
                bx_q[k] <= '0;
                s_q[k]  <= '0;
            end
        end else if (adv) begin
            vld_q <= vld_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            for (int unsigned k = 0; k < LAT; k++) begin
                a_q[k]  <= a_d[k];
                bx_q[k] <= bx_d[k];
                s_q[k]  <= s_d[k];
            end
        end
    end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Scoreboard bench for csa_pipe_adder: expected results are queued on accept
// and compared in order as the adder emits them.
module tb_csa_pipe_adder;
    import csa_pipe_adder_pkg::*;

    localparam int unsigned W   = WIDTH_DEF;
    localparam int unsigned LAT = LAT_DEF;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    res_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   ready_low = 0;

    csa_pipe_adder #(
        .WIDTH      (WIDTH_DEF),
        .BLOCK      (BLOCK_DEF),
        .STAGE_BLKS (STAGE_BLKS_DEF)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    endtask

    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mcin, input logic msub);
        res_t         r;
        logic [W-1:0] bx;
        logic [W:0]   full;
        bx     = msub ? ~mb : mb;
        full   = {1'b0, ma} + {1'b0, bx} + {{W{1'b0}}, mcin};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (ma[W-1] == bx[W-1]) && (r.sum[W-1] != ma[W-1]);
        return r;
    endfunction

    // Output side: handshake rule plus in-order scoreboard compare.
    always @(negedge clock) begin
        res_t e;
        chk("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
        if (!in_ready) ready_low++;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sum", {32'd0, sum}, {32'd0, e.sum});
                chk("cout", {63'd0, cout}, {63'd0, e.cout});
                chk("ovf", {63'd0, ovf}, {63'd0, e.ovf});
            end
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic tsub);
        logic acc;
        int   waited;
        acc      = 1'b0;
        waited   = 0;
        a        = ta;
        b        = tb;
        cin      = tcin;
        sub      = tsub;
        in_valid = 1'b1;
        while (!acc && waited < 100) begin
            @(negedge clock);
            acc = in_ready;
            if (acc) sb.push_back(model(ta, tb, tcin, tsub));
            @(posedge clock);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    // Sends one beat alone and counts cycles from the accept cycle to out_valid.
    task automatic latency_probe(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tcin, input logic tsub, input string tag);
        int cyc;
        send(ta, tb, tcin, tsub);
        cyc = 1;
        @(negedge clock);
        while (!out_valid && cyc < 20) begin
            cyc++;
            @(negedge clock);
        end
        chk(tag, 64'(cyc), 64'(LAT));
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(posedge clock);
            #1;
            waited++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #3;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", {32'd0, sum}, 64'd0);
        chk("rst_cout_ovf", {62'd0, cout, ovf}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        #14 reset = 1'b0;
        @(posedge clock);
        #1;

        latency_probe(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, "latency_add");
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD);
        send(32'h0000_0005, 32'h0000_0007, 1'b1, OP_SUB);
        send(32'h8000_0000, 32'h0000_0001, 1'b1, OP_SUB);
        send(32'h0000_FFFF, 32'h0000_0001, 1'b0, OP_ADD);
        send(32'h0000_FFFF, 32'h0000_0000, 1'b1, OP_ADD);
        drain();

        ready_low = 0;
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    logic [W-1:0] ia;
                    logic [W-1:0] ib;
                    logic [31:0]  iv;
                    iv = i;
                    ia = 32'hFFFF_FFF0 + W'(i / 2);
                    ib = 32'h7FFF_FFFC + W'(i / 4);
                    send(ia, ib, iv[0], iv[3]);
                end
            end
            begin
                repeat (20) @(posedge clock);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_cycles", 64'(ready_low), 64'd3);

        send(32'h1234_5678, 32'h0101_0101, 1'b0, OP_ADD);
        send(32'h0000_00AA, 32'h0000_0055, 1'b1, OP_ADD);
        #1;
        sb.delete();
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_sum", {32'd0, sum}, 64'd0);
        chk("mid_rst_cout_ovf", {62'd0, cout, ovf}, 64'd0);
        repeat (2) @(posedge clock);
        #4 reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        latency_probe(32'h0000_0003, 32'h0000_0004, 1'b0, OP_ADD, "latency_post_rst");
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
